instruction_fetch_sequencer: RTL and testbench
==============================================

# instruction_fetch_sequencer

Sequences the combinational 128-word instruction memory. Holds the program counter and drives the memory address. Captures each fetched word into an IF/ID output register with a valid flag. Honours stall and branch-redirect requests from downstream, and halts with a fault code on illegal fetch addresses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `IMEM_WORDS`, 128, instruction memory depth; legal byte addresses are 0 .. 4*IMEM_WORDS-4.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst_n`  in  1  reset; asynchronous and active-low.
- `Run`  in  1  level; leaves IDLE when 1.
- `Stall`  in  1  downstream not ready; holds PC and the IF/ID register.
- `BranchTaken`  in  1  redirect request, single-cycle pulse.
- `BranchTarget`  in  32  redirect byte address.
- `IMemInstruction`  in  32  combinational read data from instruction memory.
- `IMemAddress`  out  32  byte address to instruction memory; always equals PC.
- `Instruction_IF`  out  32  registered fetched word.
- `PC_IF`  out  32  byte address of `Instruction_IF`.
- `PCPlus4_IF`  out  32  `PC_IF` + 4.
- `Valid_IF`  out  1  IF/ID register holds a real instruction.
- `Halted`  out  1  FSM in HALT.
- `Fault`  out  2  00 none, 01 misaligned target, 10 out-of-range PC.
- `FetchCount`  out  32  count of accepted fetches.

## Operation
- States: IDLE, FETCH, HALT. Reset enters IDLE.
- IDLE -> FETCH when `Run`=1. No fetch occurs in IDLE. `Valid_IF`=0.
- FETCH sub-cases are evaluated each cycle in this priority order:
  1. **Redirect** (`BranchTaken`=1), taken regardless of `Stall`:
     - `BranchTarget[1:0]`≠0 -> HALT, `Fault`=01.
     - Target ≥ 4*IMEM_WORDS -> HALT, `Fault`=10.
     - Otherwise PC <= `BranchTarget` and `Valid_IF` <= 0 (bubble). `Instruction_IF` and `PC_IF` are held.
  2. **Stall** (`Stall`=1): PC, all IF/ID outputs and `FetchCount` hold.
  3. **Accept**: `Instruction_IF` <= `IMemInstruction`, `PC_IF` <= PC, `PCPlus4_IF` <= PC+4, `Valid_IF` <= 1, `FetchCount` += 1.
     - If PC+4 ≥ 4*IMEM_WORDS: the current word is still accepted. The next cycle enters HALT with `Fault`=10, and PC is not advanced.
     - Otherwise PC <= PC+4.
- HALT:
  - Absorbing; exit only via `Rst_n`.
  - `Valid_IF` <= 0 on entry. PC and the other IF/ID outputs hold.
  - `Stall`, `BranchTaken` and `Run` are ignored.
- `Run` is sampled only in IDLE. Deasserting it during FETCH has no effect.
- Arithmetic:
  - PC+4 is 32-bit modular; the range check fires before any wrap.
  - `FetchCount` wraps 32'hFFFF_FFFF -> 0.
- Memory indexing uses `IMemAddress[8:2]`. The block guarantees `IMemAddress[1:0]`=00 at all times.

## Timing
- Reset (async assert, sync deassert by the system):
  - PC = `RESET_PC`, state = IDLE.
  - `Instruction_IF`=0, `PC_IF`=0, `PCPlus4_IF`=0, `Valid_IF`=0.
  - `Halted`=0, `Fault`=00, `FetchCount`=0.
- Reset asserted mid-fetch or mid-stall clears everything immediately, with no clock required.
- Entering FETCH: `Run` sampled 1 at edge k gives state FETCH after k. The first accept is at edge k+1, so `Valid_IF`=1 after k+1.
- Fetch latency: one cycle from PC to the IF/ID outputs. Steady-state throughput is one word per cycle with `Stall`=0.
- Redirect timing:
  - A redirect at edge k produces `Valid_IF`=0 after k.
  - The target word appears after k+1 if `Stall`=0 at that edge.
  - The one-bubble penalty is fixed.
- `Halted` and `Fault` are registered and change on the same edge as the state.

## Test plan
- Straight-line fetch:
  - Stimulus: reset, then `Run`=1 for 1 cycle, `Stall`=0.
  - Required: after 4 accepts, `PC_IF`=0x0C, `Instruction_IF`=9, `PCPlus4_IF`=0x10, `FetchCount`=4.
  - Each accepted word equals (PC_IF/4)*3.
- Stall hold:
  - Stimulus: hold `Stall`=1 for 3 cycles while `PC_IF`=0x08.
  - Required: outputs frozen (`Instruction_IF`=6, `FetchCount` unchanged). The next accept gives `PC_IF`=0x0C.
- Redirect during stall:
  - Stimulus: `BranchTaken`=1, `BranchTarget`=0x40, `Stall`=1.
  - Required: `Valid_IF`=0 after 1 edge. With `Stall`=0, the next edge gives `PC_IF`=0x40, `Instruction_IF`=48.
- Misaligned redirect:
  - Stimulus: `BranchTarget`=0x22.
  - Required: `Halted`=1, `Fault`=01, `Valid_IF`=0. Later `Stall`, `BranchTaken` and `Run` have no effect.
- End of memory:
  - Stimulus: branch to 0x1F8 and run.
  - Required: accepts at 0x1F8 (378) and 0x1FC (381), then `Halted`=1, `Fault`=10, `FetchCount`=2 since the branch.
  - Also: a branch to 0x200 halts immediately with `Fault`=10.
- Async reset mid-run:
  - Stimulus: drop `Rst_n` between clock edges during FETCH.
  - Required: all outputs go to reset values at once, and state returns to IDLE.

Source files
------------

// File: rtl/instruction_fetch_sequencer_if.sv
// Bundles the fetch-stage control inputs, the instruction memory port and the
// IF/ID outputs so the sequencer and its driver share one signal set.
interface instruction_fetch_sequencer_if;
  logic        Run;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IMemInstruction;
  logic [31:0] IMemAddress;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_IF;
  logic [31:0] PCPlus4_IF;
  logic        Valid_IF;
  logic        Halted;
  logic [1:0]  Fault;
  logic [31:0] FetchCount;

  // Driver side: pipeline control plus the instruction memory model
  modport master (
    output Run, Stall, BranchTaken, BranchTarget, IMemInstruction,
    input  IMemAddress, Instruction_IF, PC_IF, PCPlus4_IF,
    input  Valid_IF, Halted, Fault, FetchCount
  );

  // Sequencer side
  modport slave (
    input  Run, Stall, BranchTaken, BranchTarget, IMemInstruction,
    output IMemAddress, Instruction_IF, PC_IF, PCPlus4_IF,
    output Valid_IF, Halted, Fault, FetchCount
  );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses a combinational
// instruction memory, and captures each fetched word into the IF/ID register.
// Downstream may stall or redirect; illegal fetch addresses halt the block
// with a fault code until the next reset.
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input logic                           Clk,
  input logic                           Rst_n,
  instruction_fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0]  FAULT_NONE       = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0]  FAULT_RANGE      = 2'b10;
  localparam logic [32:0] MEM_LIMIT        = 33'(4 * IMEM_WORDS);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic [31:0] r_pcIf;
  logic [31:0] r_pcPlus4If;
  logic        r_valid;
  logic        r_halted;
  logic [1:0]  r_fault;
  logic [31:0] r_fetchCount;
  logic        r_endPending;

  logic [31:0] w_pcPlus4;
  logic        w_lastWord;
  logic        w_targetMisaligned;
  logic        w_targetOutOfRange;

  // Range checks are done one bit wider so they fire before any 32-bit wrap
  assign w_pcPlus4          = r_pc + 32'd4;
  assign w_lastWord         = ({1'b0, r_pc} + 33'd4) >= MEM_LIMIT;
  assign w_targetMisaligned = |bus.BranchTarget[1:0];
  assign w_targetOutOfRange = {1'b0, bus.BranchTarget} >= MEM_LIMIT;

  assign bus.IMemAddress    = r_pc;
  assign bus.Instruction_IF = r_instruction;
  assign bus.PC_IF          = r_pcIf;
  assign bus.PCPlus4_IF     = r_pcPlus4If;
  assign bus.Valid_IF       = r_valid;
  assign bus.Halted         = r_halted;
  assign bus.Fault          = r_fault;
  assign bus.FetchCount     = r_fetchCount;

  // Sequencer FSM with PC, IF/ID register, fault and fetch counter all registered
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= IDLE;
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_instruction <= 32'd0;
      r_pcIf        <= 32'd0;
      r_pcPlus4If   <= 32'd0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= FAULT_NONE;
      r_fetchCount  <= 32'd0;
      r_endPending  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (bus.Run) begin
            r_state <= FETCH;
          end
        end

        FETCH: begin
          if (r_endPending) begin
            // The last memory word was accepted on the previous edge; the PC
            // was left on it, so this cycle only completes the halt.
            r_state      <= HALT;
            r_halted     <= 1'b1;
            r_fault      <= FAULT_RANGE;
            r_valid      <= 1'b0;
            r_endPending <= 1'b0;
          end else if (bus.BranchTaken) begin
            if (w_targetMisaligned) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
              r_fault  <= FAULT_MISALIGNED;
              r_valid  <= 1'b0;
            end else if (w_targetOutOfRange) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
              r_fault  <= FAULT_RANGE;
              r_valid  <= 1'b0;
            end else begin
              r_pc    <= bus.BranchTarget;
              r_valid <= 1'b0;
            end
          end else if (!bus.Stall) begin
            r_instruction <= bus.IMemInstruction;
            r_pcIf        <= r_pc;
            r_pcPlus4If   <= w_pcPlus4;
            r_valid       <= 1'b1;
            r_fetchCount  <= r_fetchCount + 32'd1;
            if (w_lastWord) begin
              r_endPending <= 1'b1;
            end else begin
              r_pc <= w_pcPlus4;
            end
          end
        end

        HALT: begin
          r_valid <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed testbench for instruction_fetch_sequencer. A behavioural memory
// returns word index * 3 for every address so fetched data is predictable.
module tb_instruction_fetch_sequencer;

  logic Clk;
  logic Rst_n;
  int   checkCount;
  int   errorCount;

  instruction_fetch_sequencer_if bus ();

  instruction_fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (128)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Combinational instruction memory model: word at index i holds i*3
  assign bus.IMemInstruction = 32'(bus.IMemAddress[8:2]) * 32'd3;

  // Counts one comparison and reports it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives the control inputs, then advances one rising edge and settles
  task automatic applyStimulus(input logic run, input logic stall,
                               input logic branch, input logic [31:0] target);
    bus.Run          = run;
    bus.Stall        = stall;
    bus.BranchTaken  = branch;
    bus.BranchTarget = target;
    @(posedge Clk);
    #1;
  endtask

  // Holds reset across one edge and releases it away from the clock edge
  task automatic applyReset();
    bus.Run          = 1'b0;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'd0;
    Rst_n = 1'b0;
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  // Compares every output against its reset value
  task automatic checkResetState(input string prefix);
    checkOutput({prefix, "_addr"},   bus.IMemAddress,    32'h0);
    checkOutput({prefix, "_instr"},  bus.Instruction_IF, 32'h0);
    checkOutput({prefix, "_pcif"},   bus.PC_IF,          32'h0);
    checkOutput({prefix, "_pc4"},    bus.PCPlus4_IF,     32'h0);
    checkOutput({prefix, "_valid"},  32'(bus.Valid_IF),  32'h0);
    checkOutput({prefix, "_halted"}, 32'(bus.Halted),    32'h0);
    checkOutput({prefix, "_fault"},  32'(bus.Fault),     32'h0);
    checkOutput({prefix, "_count"},  bus.FetchCount,     32'h0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    Rst_n      = 1'b0;
    bus.Run          = 1'b0;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'd0;
    #1;
    $display("[TB] reset state");
    checkResetState("rst");

    // Straight-line fetch with a stall while PC_IF = 0x08
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("enter_valid", 32'(bus.Valid_IF), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("seq_pcif",  bus.PC_IF,          32'(i * 4));
      checkOutput("seq_instr", bus.Instruction_IF, 32'(i * 3));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    end
    checkOutput("stall_instr", bus.Instruction_IF, 32'd6);
    checkOutput("stall_pcif",  bus.PC_IF,          32'h08);
    checkOutput("stall_count", bus.FetchCount,     32'd3);
    checkOutput("stall_valid", 32'(bus.Valid_IF),  32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("line_pcif",  bus.PC_IF,          32'h0C);
    checkOutput("line_instr", bus.Instruction_IF, 32'd9);
    checkOutput("line_pc4",   bus.PCPlus4_IF,     32'h10);
    checkOutput("line_count", bus.FetchCount,     32'd4);
    checkOutput("line_addr",  bus.IMemAddress,    32'h10);

    // Redirect while stalled still takes effect and inserts one bubble
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    checkOutput("redir_valid", 32'(bus.Valid_IF), 32'h0);
    checkOutput("redir_pcif",  bus.PC_IF,         32'h0C);
    checkOutput("redir_addr",  bus.IMemAddress,   32'h40);
    checkOutput("redir_count", bus.FetchCount,    32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("tgt_pcif",  bus.PC_IF,          32'h40);
    checkOutput("tgt_instr", bus.Instruction_IF, 32'd48);
    checkOutput("tgt_valid", 32'(bus.Valid_IF),  32'h1);
    checkOutput("tgt_count", bus.FetchCount,     32'd5);

    // End of memory: two accepts, then halt with range fault
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1F8);
    checkOutput("eom_bubble", 32'(bus.Valid_IF), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("eom_pcif0",  bus.PC_IF,          32'h1F8);
    checkOutput("eom_instr0", bus.Instruction_IF, 32'd378);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("eom_pcif1",  bus.PC_IF,          32'h1FC);
    checkOutput("eom_instr1", bus.Instruction_IF, 32'd381);
    checkOutput("eom_pc4",    bus.PCPlus4_IF,     32'h200);
    checkOutput("eom_valid1", 32'(bus.Valid_IF),  32'h1);
    checkOutput("eom_nohalt", 32'(bus.Halted),    32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("eom_halted", 32'(bus.Halted),    32'h1);
    checkOutput("eom_fault",  32'(bus.Fault),     32'h2);
    checkOutput("eom_valid",  32'(bus.Valid_IF),  32'h0);
    checkOutput("eom_count",  bus.FetchCount,     32'd7);
    checkOutput("eom_addr",   bus.IMemAddress,    32'h1FC);
    checkOutput("eom_hold",   bus.PC_IF,          32'h1FC);

    // Async reset between edges during FETCH
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("pre_count", bus.FetchCount, 32'd2);
    #2;
    Rst_n = 1'b0;
    #1;
    checkResetState("async");
    #1;
    Rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("idle_valid", 32'(bus.Valid_IF), 32'h0);
    checkOutput("idle_count", bus.FetchCount,    32'd0);
    checkOutput("idle_addr",  bus.IMemAddress,   32'h0);

    // Branch exactly to the memory limit halts at once
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("lim_count0", bus.FetchCount, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    checkOutput("lim_halted", 32'(bus.Halted),   32'h1);
    checkOutput("lim_fault",  32'(bus.Fault),    32'h2);
    checkOutput("lim_valid",  32'(bus.Valid_IF), 32'h0);
    checkOutput("lim_addr",   bus.IMemAddress,   32'h4);

    // Misaligned branch halts; later inputs are ignored
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22);
    checkOutput("mis_halted", 32'(bus.Halted),   32'h1);
    checkOutput("mis_fault",  32'(bus.Fault),    32'h1);
    checkOutput("mis_valid",  32'(bus.Valid_IF), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("abs_halted", 32'(bus.Halted),   32'h1);
    checkOutput("abs_fault",  32'(bus.Fault),    32'h1);
    checkOutput("abs_valid",  32'(bus.Valid_IF), 32'h0);
    checkOutput("abs_count",  bus.FetchCount,    32'd1);
    checkOutput("abs_pcif",   bus.PC_IF,         32'h0);
    checkOutput("abs_addr",   bus.IMemAddress,   32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
